sd_bd_queue: RTL and testbench
==============================

Name: sd_bd_queue

Overview:
Parametrised buffer-descriptor (BD) queue between the host register interface (main side) and the SD DMA engine (slave side). The host pushes descriptors as WORDS_PER_BD consecutive words. The DMA engine pops them one word at a time. Each slot is held until the engine signals transfer completion. Width, words per descriptor and depth are generic. The block adds explicit ready/in-flight accounting, error flags, flush, and last-word marking.

Parameters:
DATA_W, 32, word width of dat_in_m / dat_out_s
WORDS_PER_BD, 2, words per descriptor (>=1; not required to be a power of 2)
BD_DEPTH, 8, descriptor slots (>=2, power of 2)
CNT_W, clog2(BD_DEPTH)+1, derived localparam; width of all counts

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous queue clear
we_m  in  1  main-side word write strobe
dat_in_m  in  DATA_W  main-side write data
wr_err  out  1  pulse: write rejected, queue full
free_bd  out  CNT_W  slots neither committed nor in flight
ready_bd  out  CNT_W  committed BDs not yet fully read
re_s  in  1  slave-side word read strobe
ack_o_s  out  1  pulse: dat_out_s valid
dat_out_s  out  DATA_W  slave-side read data
bd_last_s  out  1  high with ack_o_s on the last word of a BD
rd_err  out  1  pulse: read rejected, nothing ready
a_cmp  in  1  level: transfer complete; its rising edge releases one BD
rel_err  out  1  pulse: release with no BD in flight

Behaviour:
- Storage: BD_DEPTH*WORDS_PER_BD words. Word pointers wr_ptr and rd_ptr wrap explicitly to 0 after the last index. Sub-counters wr_word and rd_word count 0..WORDS_PER_BD-1.
- Internal count inflight: BDs fully read but not released. Invariant every cycle: free_bd + ready_bd + inflight == BD_DEPTH.
- Reset (rst=1) values: free_bd=BD_DEPTH; ready_bd=0; inflight=0; all pointers and sub-counters 0; dat_out_s=0; ack_o_s, bd_last_s, wr_err, rd_err, rel_err = 0; a_cmp history register = 0.
- Priority: rst > flush > normal operation.
- Write accept: we_m=1 and free_bd>0.
  - Store dat_in_m at wr_ptr, advance wr_ptr and wr_word.
  - When wr_word==WORDS_PER_BD-1 the BD commits: wr_word->0, free_bd-1, ready_bd+1, all in the next cycle.
  - A partially written BD is not visible to the slave side.
- Write reject: we_m=1 and free_bd==0. wr_err pulses for 1 cycle; no state change.
- Read accept: re_s=1 and ready_bd>0 (registered value).
  - Next cycle: dat_out_s=mem[rd_ptr], ack_o_s=1. Latency is 1 cycle.
  - rd_ptr and rd_word advance.
  - On rd_word==WORDS_PER_BD-1: bd_last_s=1 with that ack, rd_word->0, ready_bd-1, inflight+1.
- Read reject: re_s=1 and ready_bd==0. rd_err pulses; ack_o_s stays 0; dat_out_s holds.
- Between reads, dat_out_s holds its last value.
- A BD committed in cycle N is readable from cycle N+1. Back-to-back re_s gives one word per cycle.
- Release: a_cmp=1 while the history register is 0 (rising edge).
  - If inflight>0: inflight-1, free_bd+1.
  - Else: rel_err pulses, no change.
  - a_cmp held high releases exactly one BD.
- Simultaneous events: each counter applies its +1 and -1 in the same cycle, so net is unchanged.
  - commit + release: free_bd unchanged.
  - commit + last-word read: ready_bd unchanged.
  - last-word read + release: inflight unchanged.
- Write and read never address the same word in the same cycle: committed words are never overwritten before release.
- Flush: same clear as reset, except the a_cmp history register loads a_cmp. This prevents a spurious release if a_cmp is high during flush. Any partially written BD is discarded.
- WORDS_PER_BD=1: every accepted write commits, and every read asserts bd_last_s.

Test Plan:
(Default: DATA_W=32, WORDS_PER_BD=2, BD_DEPTH=4 unless stated.)
- Basic flow: write 0xA0,0xB0 -> free_bd 4->3, ready_bd 0->1. Two re_s -> acks with 0xA0 then 0xB0, bd_last_s on the second, ready_bd=0. a_cmp rising -> free_bd=4.
- Full: 8 writes -> free_bd=0. A ninth write -> wr_err=1 for one cycle; the memory word at wr_ptr is unchanged.
- Empty / partial: re_s with ready_bd=0 -> rd_err pulse, no ack. Then 1 write plus re_s -> still rd_err; the partial BD stays hidden.
- Simultaneous: with 1 BD in flight and free_bd=1, commit a BD in the same cycle as an a_cmp rising edge -> free_bd stays 1, ready_bd +1.
- Release rules: a_cmp held high for 5 cycles -> exactly one release. a_cmp edge with inflight=0 -> rel_err pulse, free_bd unchanged.
- Flush and wrap: 3 writes, flush with a_cmp=1 -> free_bd=4, no release on a_cmp. Then a 12-BD write/read/release loop -> pointers wrap and data order is preserved.
- WORDS_PER_BD=3, BD_DEPTH=2: 6 writes fill the queue; reads return words in order with bd_last_s on words 3 and 6.

Source files
------------

// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue between the host register port and the SD DMA engine.
// Descriptors are pushed and popped word by word; a slot stays owned until a_cmp releases it.
module sd_bd_queue #(
    parameter int  DATA_W       = 32,
    parameter int  WORDS_PER_BD = 2,
    parameter int  BD_DEPTH     = 8,
    localparam int CNT_W        = $clog2(BD_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              we_m,
    input  logic [DATA_W-1:0] dat_in_m,
    output logic              wr_err,
    output logic [CNT_W-1:0]  free_bd,
    output logic [CNT_W-1:0]  ready_bd,
    input  logic              re_s,
    output logic              ack_o_s,
    output logic [DATA_W-1:0] dat_out_s,
    output logic              bd_last_s,
    output logic              rd_err,
    input  logic              a_cmp,
    output logic              rel_err
);

    localparam int MEM_WORDS = BD_DEPTH * WORDS_PER_BD;
    localparam int PTR_W     = $clog2(MEM_WORDS);
    localparam int SUB_W     = (WORDS_PER_BD > 1) ? $clog2(WORDS_PER_BD) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MEM_WORDS - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(WORDS_PER_BD - 1);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SUB_W-1:0] wr_word;
    logic [SUB_W-1:0] rd_word;
    logic [CNT_W-1:0] inflight;
    logic             a_cmp_q;

    logic active;
    logic wr_acc;
    logic wr_commit;
    logic rd_acc;
    logic rd_last;
    logic rel_edge;
    logic rel_acc;

    always_comb begin
        active    = !rst && !flush;
        wr_acc    = active && we_m && (free_bd != '0);
        wr_commit = wr_acc && (wr_word == SUB_LAST);
        rd_acc    = active && re_s && (ready_bd != '0);
        rd_last   = rd_acc && (rd_word == SUB_LAST);
        rel_edge  = a_cmp && !a_cmp_q;
        rel_acc   = active && rel_edge && (inflight != '0);
    end

    // Committed words are only reused after release, so a write never hits the word being read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= dat_in_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_word   <= '0;
            rd_word   <= '0;
            free_bd   <= CNT_W'(BD_DEPTH);
            ready_bd  <= '0;
            inflight  <= '0;
            dat_out_s <= '0;
            ack_o_s   <= 1'b0;
            bd_last_s <= 1'b0;
            wr_err    <= 1'b0;
            rd_err    <= 1'b0;
            rel_err   <= 1'b0;
            // On flush the history tracks a_cmp so a level already high is not seen as an edge.
            a_cmp_q   <= rst ? 1'b0 : a_cmp;
        end else begin
            a_cmp_q   <= a_cmp;
            wr_err    <= we_m && (free_bd == '0);
            rd_err    <= re_s && (ready_bd == '0);
            rel_err   <= rel_edge && (inflight == '0);
            ack_o_s   <= rd_acc;
            bd_last_s <= rd_last;

            if (wr_acc) begin
                wr_ptr  <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
                wr_word <= wr_commit ? '0 : wr_word + SUB_W'(1);
            end

            if (rd_acc) begin
                dat_out_s <= mem[rd_ptr];
                rd_ptr    <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
                rd_word   <= rd_last ? '0 : rd_word + SUB_W'(1);
            end

            free_bd  <= free_bd - CNT_W'(wr_commit) + CNT_W'(rel_acc);
            ready_bd <= ready_bd + CNT_W'(wr_commit) - CNT_W'(rd_last);
            inflight <= inflight + CNT_W'(rd_last) - CNT_W'(rel_acc);
        end
    end

endmodule

// File: tb/tb_sd_bd_queue.sv
// Directed bench for sd_bd_queue: a 2-word/4-slot queue and a 3-word/2-slot queue.
module tb_sd_bd_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        we_m = 1'b0;
    logic [31:0] dat_in_m = '0;
    logic        wr_err;
    logic [2:0]  free_bd;
    logic [2:0]  ready_bd;
    logic        re_s = 1'b0;
    logic        ack_o_s;
    logic [31:0] dat_out_s;
    logic        bd_last_s;
    logic        rd_err;
    logic        a_cmp = 1'b0;
    logic        rel_err;

    sd_bd_queue #(.DATA_W(32), .WORDS_PER_BD(2), .BD_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .we_m(we_m), .dat_in_m(dat_in_m),
        .wr_err(wr_err), .free_bd(free_bd), .ready_bd(ready_bd), .re_s(re_s),
        .ack_o_s(ack_o_s), .dat_out_s(dat_out_s), .bd_last_s(bd_last_s),
        .rd_err(rd_err), .a_cmp(a_cmp), .rel_err(rel_err)
    );

    logic        we_b = 1'b0;
    logic [31:0] din_b = '0;
    logic        wr_err_b;
    logic [1:0]  free_b;
    logic [1:0]  ready_b;
    logic        re_b = 1'b0;
    logic        ack_b;
    logic [31:0] dout_b;
    logic        last_b;
    logic        rd_err_b;
    logic        rel_err_b;

    sd_bd_queue #(.DATA_W(32), .WORDS_PER_BD(3), .BD_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .flush(1'b0), .we_m(we_b), .dat_in_m(din_b),
        .wr_err(wr_err_b), .free_bd(free_b), .ready_bd(ready_b), .re_s(re_b),
        .ack_o_s(ack_b), .dat_out_s(dout_b), .bd_last_s(last_b),
        .rd_err(rd_err_b), .a_cmp(1'b0), .rel_err(rel_err_b)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_dat = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs set before step() are sampled at the next rising edge; outputs are read 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        we_m = 1'b1;
        dat_in_m = d;
        step();
        we_m = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] exp_d, input logic exp_last);
        re_s = 1'b1;
        step();
        re_s = 1'b0;
        check({tag, "_ack"}, 32'(ack_o_s), 32'd1);
        check({tag, "_dat"}, dat_out_s, exp_d);
        check({tag, "_last"}, 32'(bd_last_s), 32'(exp_last));
        last_dat = exp_d;
    endtask

    task automatic release_pulse();
        a_cmp = 1'b1;
        step();
        a_cmp = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        check("rst_free", 32'(free_bd), 32'd4);
        check("rst_ready", 32'(ready_bd), 32'd0);
        check("rst_ack", 32'(ack_o_s), 32'd0);
        check("rst_dat", dat_out_s, 32'd0);
        check("rst_errs", {29'd0, wr_err, rd_err, rel_err}, 32'd0);
        check("rst_free_b", 32'(free_b), 32'd2);
        rst = 1'b0;
        step();

        // basic flow
        wr(32'hA0);
        check("basic_partial_free", 32'(free_bd), 32'd4);
        check("basic_partial_ready", 32'(ready_bd), 32'd0);
        wr(32'hB0);
        check("basic_commit_free", 32'(free_bd), 32'd3);
        check("basic_commit_ready", 32'(ready_bd), 32'd1);
        rd("basic_r0", 32'hA0, 1'b0);
        rd("basic_r1", 32'hB0, 1'b1);
        check("basic_ready0", 32'(ready_bd), 32'd0);
        check("basic_free_inflight", 32'(free_bd), 32'd3);
        step();
        check("basic_ack_drop", 32'(ack_o_s), 32'd0);
        check("basic_dat_hold", dat_out_s, 32'hB0);
        a_cmp = 1'b1;
        step();
        check("basic_release", 32'(free_bd), 32'd4);
        check("basic_no_relerr", 32'(rel_err), 32'd0);
        a_cmp = 1'b0;
        step();

        // a_cmp held high releases one BD only; then an edge with nothing in flight
        for (int i = 0; i < 4; i++) wr(32'h20 + 32'(i));
        for (int i = 0; i < 4; i++) rd("hold_rd", 32'h20 + 32'(i), i[0]);
        check("hold_pre_free", 32'(free_bd), 32'd2);
        a_cmp = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("hold_one_release", 32'(free_bd), 32'd3);
        a_cmp = 1'b0;
        step();
        release_pulse();
        check("hold_second_release", 32'(free_bd), 32'd4);
        a_cmp = 1'b1;
        step();
        check("relerr_pulse", 32'(rel_err), 32'd1);
        check("relerr_free", 32'(free_bd), 32'd4);
        a_cmp = 1'b0;
        step();
        check("relerr_clear", 32'(rel_err), 32'd0);

        // empty and partially written BD
        re_s = 1'b1;
        step();
        re_s = 1'b0;
        check("empty_rderr", 32'(rd_err), 32'd1);
        check("empty_noack", 32'(ack_o_s), 32'd0);
        check("empty_dat_hold", dat_out_s, last_dat);
        step();
        check("empty_rderr_clear", 32'(rd_err), 32'd0);
        wr(32'h55);
        re_s = 1'b1;
        step();
        re_s = 1'b0;
        check("partial_rderr", 32'(rd_err), 32'd1);
        check("partial_noack", 32'(ack_o_s), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("partial_flush_free", 32'(free_bd), 32'd4);
        check("partial_flush_ready", 32'(ready_bd), 32'd0);

        // full queue and rejected write
        for (int i = 0; i < 8; i++) wr(32'h10 + 32'(i));
        check("full_free", 32'(free_bd), 32'd0);
        check("full_ready", 32'(ready_bd), 32'd4);
        wr(32'hFF);
        check("full_wrerr", 32'(wr_err), 32'd1);
        check("full_free_hold", 32'(free_bd), 32'd0);
        step();
        check("full_wrerr_clear", 32'(wr_err), 32'd0);
        for (int i = 0; i < 8; i++) rd("full_rd", 32'h10 + 32'(i), i[0]);
        for (int i = 0; i < 4; i++) release_pulse();
        check("full_drained", 32'(free_bd), 32'd4);

        // commit coincides with a release
        wr(32'h40);
        wr(32'h41);
        rd("sim_r0", 32'h40, 1'b0);
        rd("sim_r1", 32'h41, 1'b1);
        for (int i = 0; i < 4; i++) wr(32'h42 + 32'(i));
        wr(32'h46);
        check("sim_pre_free", 32'(free_bd), 32'd1);
        we_m = 1'b1;
        dat_in_m = 32'h47;
        a_cmp = 1'b1;
        step();
        we_m = 1'b0;
        check("sim_free", 32'(free_bd), 32'd1);
        check("sim_ready", 32'(ready_bd), 32'd3);
        check("sim_no_relerr", 32'(rel_err), 32'd0);
        a_cmp = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;

        // flush while a_cmp is high must not look like a release edge
        for (int i = 0; i < 3; i++) wr(32'h60 + 32'(i));
        check("flush_pre_free", 32'(free_bd), 32'd3);
        flush = 1'b1;
        a_cmp = 1'b1;
        step();
        flush = 1'b0;
        check("flush_free", 32'(free_bd), 32'd4);
        check("flush_ready", 32'(ready_bd), 32'd0);
        check("flush_dat", dat_out_s, 32'd0);
        step();
        check("flush_no_edge", 32'(rel_err), 32'd0);
        check("flush_free_after", 32'(free_bd), 32'd4);
        a_cmp = 1'b0;
        step();

        // 12 BDs through the queue: pointers wrap, order is kept
        for (int i = 0; i < 12; i++) begin
            wr(32'h100 + 32'(2 * i));
            wr(32'h101 + 32'(2 * i));
            rd("wrap_r0", 32'h100 + 32'(2 * i), 1'b0);
            rd("wrap_r1", 32'h101 + 32'(2 * i), 1'b1);
            release_pulse();
        end
        check("wrap_free", 32'(free_bd), 32'd4);
        check("wrap_ready", 32'(ready_bd), 32'd0);

        // three-word descriptors, two slots
        for (int i = 0; i < 6; i++) begin
            we_b = 1'b1;
            din_b = 32'h31 + 32'(i);
            step();
        end
        we_b = 1'b0;
        check("b_full_free", 32'(free_b), 32'd0);
        check("b_full_ready", 32'(ready_b), 32'd2);
        we_b = 1'b1;
        din_b = 32'hEE;
        step();
        we_b = 1'b0;
        check("b_wrerr", 32'(wr_err_b), 32'd1);
        for (int i = 0; i < 6; i++) begin
            re_b = 1'b1;
            step();
            check("b_ack", 32'(ack_b), 32'd1);
            check("b_dat", dout_b, 32'h31 + 32'(i));
            check("b_last", 32'(last_b), (i == 2 || i == 5) ? 32'd1 : 32'd0);
        end
        re_b = 1'b0;
        check("b_ready0", 32'(ready_b), 32'd0);
        check("b_free_inflight", 32'(free_b), 32'd0);
        re_b = 1'b1;
        step();
        re_b = 1'b0;
        check("b_rderr", 32'(rd_err_b), 32'd1);
        check("b_no_relerr", 32'(rel_err_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
